toy_cpu_pipe: RTL and testbench
===============================

TOY_CPU_PIPE -- requirements
Module: toy_cpu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning datapath and register width; it must be a power of 2 and at least 4.
REQ-002 The block SHALL have parameter NREGS, default 8, meaning register count; it must be a power of 2 and at least 2. AW = $clog2(NREGS).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port op_valid, input, 1 bit: an instruction is presented.
REQ-006 The block SHALL have port op_ready, output, 1 bit: the instruction is accepted on the edge where op_valid && op_ready.
REQ-007 The block SHALL have ports opcode (input, 3 bits), src_a, src_b and dest (input, AW bits each) and imm (input, WIDTH bits): the instruction fields.
REQ-008 The block SHALL have port out, output, WIDTH bits: the result.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out holds an unconsumed result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the result is consumed on the edge where out_valid && out_ready.
REQ-011 The block SHALL have ports out_carry and out_zero, output, 1 bit each: flags belonging to out.

Function
REQ-012 Opcodes SHALL be: 0 ADD a+b, 1 SUB a-b, 2 AND, 3 OR, 4 XOR, 5 SHL a<<b[log2(WIDTH)-1:0], 6 ADDI a+imm, 7 LI imm. Opcodes 0-5 read a and b; opcode 6 reads a only; opcode 7 reads nothing.
REQ-013 Register r0 SHALL read as 0; writes to r0 are discarded, but the result still appears on out.
REQ-014 The pipeline SHALL have two stages: S1 (operands latched at acceptance) and S2 (the out/flag register). Writeback to the register file SHALL occur on the same edge as S1->S2 transfer.
REQ-015 S1 SHALL advance when s1_valid && (!out_valid || out_ready). Latency SHALL be 2 edges from acceptance to out_valid=1 when no stall occurs. Throughput SHALL be 1 instruction per cycle.
REQ-016 op_ready SHALL be rst && (!s1_valid || S1 advances) && !stall_hazard, as defined in REQ-024.
REQ-017 out_carry SHALL be the carry-out of ADD/ADDI and the borrow of SUB. It SHALL be 0 for opcodes 2-5 and 7.
REQ-018 out_zero SHALL be (result == 0) for all opcodes.
REQ-019 out, out_carry and out_zero SHALL be held stable while out_valid && !out_ready. When out is consumed and there is no S1 advance, out_valid SHALL fall to 0 and out SHALL hold its last value.
REQ-020 When an operand is read with src equal to the S1 dest (non-zero) while S1 is valid, that is a RAW hazard, handled per REQ-024.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; all operands are unsigned.

Reset
REQ-022 With rst=0 at an edge, all registers, out, out_carry, out_zero, out_valid and s1_valid SHALL be cleared to 0. Any instruction in flight SHALL be discarded with no writeback.
REQ-023 op_ready SHALL be 0 while rst=0. It SHALL become 1 in the first cycle with rst=1.

Configuration
REQ-024 With macro TOY_CPU_FWD_EN defined, hazard operands SHALL be forwarded from the S1 ALU result and stall_hazard SHALL be 0. Without the macro, stall_hazard SHALL be 1 on a hazard, giving exactly one bubble cycle, after which the operand is read from the register file.

Verification
REQ-025 Bench SHALL cover: LI r1,0x05; LI r2,0x03; ADD r3,r1,r2, offered back-to-back -> out 0x05, 0x03, 0x08. With FWD, op_ready is constantly 1. Without FWD, op_ready is low for exactly 1 cycle while ADD is offered.
REQ-026 Bench SHALL cover: r1=0x00, r2=0x01, SUB r3,r1,r2 -> out 0xFF, carry 1, zero 0.
REQ-027 Bench SHALL cover: r1=0xFF, ADDI r2,r1,0x01 -> out 0x00, carry 1, zero 1.
REQ-028 Bench SHALL cover: LI r0,0xAA, then ADD r1,r0,r0 -> out 0xAA, then 0x00 with zero 1.
REQ-029 Bench SHALL cover: out_ready held 0 for 3 cycles during a 4-instruction stream -> out stays constant, op_ready goes 0 once S1 is full, and all 4 results are delivered in order with none lost.
REQ-030 Bench SHALL cover: rst=0 asserted while s1_valid=1 (ADD targeting r4) -> next cycle out_valid=0, r4 reads 0, op_ready=0 during reset.

Source files
------------

// File: rtl/toy_cpu_pipe.sv
// toy_cpu_pipe: two-stage toy ALU pipeline (S1 operand latch, S2 result/flag register) over a small register file.
// Define TOY_CPU_FWD_EN to forward RAW-hazard operands from the S1 ALU result instead of stalling one cycle.
module toy_cpu_pipe #(
   parameter int WIDTH = 8,
   parameter int NREGS = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       op_valid,
   output logic                       op_ready,
   input  logic [2:0]                 opcode,
   input  logic [$clog2(NREGS)-1:0]   src_a,
   input  logic [$clog2(NREGS)-1:0]   src_b,
   input  logic [$clog2(NREGS)-1:0]   dest,
   input  logic [WIDTH-1:0]           imm,
   output logic [WIDTH-1:0]           out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_carry,
   output logic                       out_zero
);
   localparam int AW = $clog2(NREGS);
   localparam int SW = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SHL  = 3'd5;
   localparam logic [2:0] OP_ADDI = 3'd6;
   localparam logic [2:0] OP_LI   = 3'd7;

   logic [WIDTH-1:0] rf_reg [NREGS];

   logic             s1_valid_reg;
   logic [2:0]       s1_op_reg;
   logic [AW-1:0]    s1_dest_reg;
   logic [WIDTH-1:0] s1_a_reg;
   logic [WIDTH-1:0] s1_b_reg;

   logic [WIDTH-1:0] out_reg;
   logic             out_valid_reg;
   logic             out_carry_reg;
   logic             out_zero_reg;

   logic [WIDTH:0]   alu_wide;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;

   logic             s1_adv;
   logic             accept;
   logic             reads_a;
   logic             reads_b;
   logic             haz_a;
   logic             haz_b;
   logic             stall_hazard;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;
   logic [WIDTH-1:0] opnd_a;
   logic [WIDTH-1:0] opnd_b;
   logic [WIDTH-1:0] s1_b_next;

   // The extra MSB carries ADD carry-out and SUB borrow; logic ops leave it 0.
   always_comb begin
      alu_wide = '0;
      case (s1_op_reg)
         OP_ADD, OP_ADDI: alu_wide = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
         OP_SUB:          alu_wide = {1'b0, s1_a_reg} - {1'b0, s1_b_reg};
         OP_AND:          alu_wide = {1'b0, s1_a_reg & s1_b_reg};
         OP_OR:           alu_wide = {1'b0, s1_a_reg | s1_b_reg};
         OP_XOR:          alu_wide = {1'b0, s1_a_reg ^ s1_b_reg};
         OP_SHL:          alu_wide = {1'b0, s1_a_reg << s1_b_reg[SW-1:0]};
         default:         alu_wide = {1'b0, s1_b_reg};
      endcase
   end

   assign alu_res   = alu_wide[WIDTH-1:0];
   assign alu_carry = alu_wide[WIDTH];

   assign s1_adv  = s1_valid_reg && (!out_valid_reg || out_ready);
   assign reads_a = (opcode != OP_LI);
   assign reads_b = (opcode <= OP_SHL);
   assign haz_a   = s1_valid_reg && (s1_dest_reg != '0) && reads_a && (src_a == s1_dest_reg);
   assign haz_b   = s1_valid_reg && (s1_dest_reg != '0) && reads_b && (src_b == s1_dest_reg);
   assign rd_a    = rf_reg[src_a];
   assign rd_b    = rf_reg[src_b];

`ifdef TOY_CPU_FWD_EN
   // Acceptance with S1 full implies S1 advances on the same edge, so its ALU result is the committed value.
   assign stall_hazard = 1'b0;
   assign opnd_a       = haz_a ? alu_res : rd_a;
   assign opnd_b       = haz_b ? alu_res : rd_b;
`else
   assign stall_hazard = haz_a | haz_b;
   assign opnd_a       = rd_a;
   assign opnd_b       = rd_b;
`endif

   assign s1_b_next = (opcode >= OP_ADDI) ? imm : opnd_b;
   assign op_ready  = rst && (!s1_valid_reg || s1_adv) && !stall_hazard;
   assign accept    = op_valid && op_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid_reg  <= 1'b0;
         s1_op_reg     <= '0;
         s1_dest_reg   <= '0;
         s1_a_reg      <= '0;
         s1_b_reg      <= '0;
         out_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_carry_reg <= 1'b0;
         out_zero_reg  <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            rf_reg[i] <= '0;
         end
      end else begin
         if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_op_reg    <= opcode;
            s1_dest_reg  <= dest;
            s1_a_reg     <= opnd_a;
            s1_b_reg     <= s1_b_next;
         end else if (s1_adv) begin
            s1_valid_reg <= 1'b0;
         end

         if (s1_adv) begin
            out_reg       <= alu_res;
            out_carry_reg <= alu_carry;
            out_zero_reg  <= (alu_res == '0);
            out_valid_reg <= 1'b1;
            if (s1_dest_reg != '0) begin
               rf_reg[s1_dest_reg] <= alu_res;
            end
         end else if (out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out       = out_reg;
   assign out_valid = out_valid_reg;
   assign out_carry = out_carry_reg;
   assign out_zero  = out_zero_reg;
endmodule

// File: tb/tb_toy_cpu_pipe.sv
// tb_toy_cpu_pipe: directed plus random instruction streams checked against a sequential-semantics reference model.
module tb_toy_cpu_pipe;
   logic       clk = 1'b0;
   logic       rst;
   logic       op_valid;
   logic       op_ready;
   logic [2:0] opcode;
   logic [2:0] src_a;
   logic [2:0] src_b;
   logic [2:0] dest;
   logic [7:0] imm;
   logic [7:0] out;
   logic       out_valid;
   logic       out_ready;
   logic       out_carry;
   logic       out_zero;

   always #5 clk = ~clk;

   toy_cpu_pipe #(.WIDTH(8), .NREGS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .opcode    (opcode),
      .src_a     (src_a),
      .src_b     (src_b),
      .dest      (dest),
      .imm       (imm),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_carry (out_carry),
      .out_zero  (out_zero)
   );

   typedef struct { int r; int c; int z; } exp_t;

   exp_t q[$];
   int   mrf[8];
   int   total = 0;
   int   bad = 0;
   int   cons_cnt = 0;
   int   stall_cnt = 0;
   int   ordy_pct = 100;
   logic last_ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Instructions execute strictly in program order against an array register file.
   function automatic void model_exec(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                      input logic [2:0] d, input logic [7:0] im);
      int va, vb, r;
      exp_t e;
      va = mrf[a];
      vb = mrf[b];
      case (op)
         3'd0:    r = va + vb;
         3'd1:    r = va - vb;
         3'd2:    r = va & vb;
         3'd3:    r = va | vb;
         3'd4:    r = va ^ vb;
         3'd5:    r = va << (vb % 8);
         3'd6:    r = va + int'(im);
         default: r = int'(im);
      endcase
      if (op == 3'd0 || op == 3'd6) e.c = int'(r > 255);
      else if (op == 3'd1)          e.c = int'(va < vb);
      else                          e.c = 0;
      e.r = r & 255;
      e.z = int'(e.r == 0);
      if (d != 3'd0) mrf[d] = e.r;
      q.push_back(e);
   endfunction

   task automatic tick(output bit acc);
      bit cons;
      @(negedge clk);
      last_ready = op_ready;
      acc  = op_valid && op_ready;
      cons = out_valid && out_ready;
      if (q.size() == 0) begin
         chk("idle_out_valid", out_valid, 0);
      end else if (out_valid) begin
         chk("out", out, q[0].r);
         chk("carry", out_carry, q[0].c);
         chk("zero", out_zero, q[0].z);
      end
      if (cons) $display("txn %0d: out=%02h carry=%0d zero=%0d", cons_cnt, out, out_carry, out_zero);
      @(posedge clk);
      #1;
      if (cons && q.size() > 0) begin
         q.delete(0);
         cons_cnt++;
      end
      if (acc) model_exec(opcode, src_a, src_b, dest, imm);
      if (stall_cnt > 0) begin
         out_ready = 1'b0;
         stall_cnt--;
      end else begin
         out_ready = ($urandom_range(99) < ordy_pct);
      end
   endtask

   task automatic offer(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] d, input logic [7:0] im, output int lows);
      bit acc;
      acc = 1'b0;
      lows = 0;
      op_valid = 1'b1;
      opcode = op;
      src_a = a;
      src_b = b;
      dest = d;
      imm = im;
      for (int k = 0; k < 40 && !acc; k++) begin
         tick(acc);
         if (!last_ready) lows++;
      end
      chk("accepted", acc, 1);
      op_valid = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      op_valid = 1'b0;
      for (int k = 0; k < 80 && q.size() > 0; k++) tick(acc);
      chk("drained", q.size(), 0);
   endtask

   initial begin
      int l0, l1, l2, lows, start;
      bit acc;
      rst = 1'b0; op_valid = 1'b0; opcode = '0; src_a = '0; src_b = '0; dest = '0; imm = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) mrf[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_op_ready", op_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out", out, 0);
      chk("rst_carry", out_carry, 0);
      chk("rst_zero", out_zero, 0);
      rst = 1'b1;
      #1;
      chk("ready_after_rst", op_ready, 1);

      // LI r1,5; LI r2,3; ADD r3,r1,r2 back-to-back
      offer(3'd7, 3'd0, 3'd0, 3'd1, 8'h05, l0);
      offer(3'd7, 3'd0, 3'd0, 3'd2, 8'h03, l1);
      offer(3'd0, 3'd1, 3'd2, 3'd3, 8'h00, l2);
      chk("li_ready_lows", l0 + l1, 0);
`ifdef TOY_CPU_FWD_EN
      chk("add_ready_lows", l2, 0);
`else
      chk("add_ready_lows", l2, 1);
`endif
      tick(acc);
      chk("add_latency", {out_valid, out}, 32'h108);
      drain();

      // SUB borrow
      offer(3'd7, 3'd0, 3'd0, 3'd1, 8'h00, l0);
      offer(3'd7, 3'd0, 3'd0, 3'd2, 8'h01, l0);
      offer(3'd1, 3'd1, 3'd2, 3'd3, 8'h00, l0);
      drain();
      chk("sub_out", out, 8'hFF);
      chk("sub_carry", out_carry, 1);
      chk("sub_zero", out_zero, 0);

      // ADDI wrap
      offer(3'd7, 3'd0, 3'd0, 3'd1, 8'hFF, l0);
      offer(3'd6, 3'd1, 3'd0, 3'd2, 8'h01, l0);
      drain();
      chk("addi_out", out, 8'h00);
      chk("addi_carry", out_carry, 1);
      chk("addi_zero", out_zero, 1);

      // r0 writes discarded but still reported
      offer(3'd7, 3'd0, 3'd0, 3'd0, 8'hAA, l0);
      drain();
      chk("li_r0_out", out, 8'hAA);
      offer(3'd0, 3'd0, 3'd0, 3'd1, 8'h00, l0);
      drain();
      chk("r0_read_out", out, 8'h00);
      chk("r0_read_zero", out_zero, 1);

      // output back-pressure for 3 cycles across a 4-instruction stream
      start = cons_cnt;
      out_ready = 1'b0;
      stall_cnt = 2;
      lows = 0;
      offer(3'd7, 3'd0, 3'd0, 3'd5, 8'h11, l0); lows += l0;
      offer(3'd7, 3'd0, 3'd0, 3'd6, 8'h22, l0); lows += l0;
      offer(3'd7, 3'd0, 3'd0, 3'd7, 8'h33, l0); lows += l0;
      offer(3'd7, 3'd0, 3'd0, 3'd1, 8'h44, l0); lows += l0;
      chk("stall_ready_lows", lows, 1);
      drain();
      chk("stall_delivered", cons_cnt - start, 4);
      chk("stall_last_out", out, 8'h44);

      // random stream with random gaps and back-pressure
      ordy_pct = 70;
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(4) == 0) tick(acc);
         offer(3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)),
               3'($urandom_range(7)), 8'($urandom_range(255)), l0);
      end
      ordy_pct = 100;
      drain();

      // reset with an ADD to r4 sitting in S1
      offer(3'd7, 3'd0, 3'd0, 3'd4, 8'h77, l0);
      drain();
      offer(3'd0, 3'd1, 3'd2, 3'd4, 8'h00, l0);
      rst = 1'b0;
      #1;
      chk("inrst_op_ready", op_ready, 0);
      @(posedge clk);
      #1;
      q.delete();
      for (int i = 0; i < 8; i++) mrf[i] = 0;
      chk("postrst_out_valid", out_valid, 0);
      chk("postrst_op_ready", op_ready, 0);
      rst = 1'b1;
      #1;
      chk("rst_release_ready", op_ready, 1);
      offer(3'd6, 3'd4, 3'd0, 3'd5, 8'h00, l0);
      drain();
      chk("r4_after_rst", out, 8'h00);
      chk("r4_after_rst_zero", out_zero, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
